// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared types and sizing for the branch-misprediction recovery path.
// The redirect struct is shared with the fetch-side consumer.
package rob_recovery_ctrl_pkg;

    localparam int DISPATCH_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        DRAIN    = 2'd2,
        REDIRECT = 2'd3
    } recovery_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } redirect_t;

endpackage

// File: rtl/rob_recovery_ctrl_oldest_mispredict_sel.sv
// Combinational priority encoder: finds the oldest committing mispredicted
// branch and masks every younger lane. The branch itself still retires.
module oldest_mispredict_sel
    import rob_recovery_ctrl_pkg::*;
#(
    parameter int W  = DISPATCH_WIDTH,
    parameter int KW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  commit_en,
    input  logic [W-1:0]  commit_mispredict,
    output logic          found,
    output logic [KW-1:0] k,
    output logic [W-1:0]  retire_mask
);

    always_comb begin
        found       = 1'b0;
        k           = '0;
        retire_mask = commit_en;
        for (int i = 0; i < W; i++) begin
            if (found) begin
                retire_mask[i] = 1'b0;
            end else if (commit_en[i] && commit_mispredict[i]) begin
                found = 1'b1;
                k     = KW'(i);
            end
        end
    end

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Recovery sequencer: mask younger commit lanes on a mispredict, pulse flush,
// hold dispatch while the back end drains, then hand the redirect to fetch.
module rob_recovery_ctrl
    import rob_recovery_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT   = 16,
    parameter int DRAIN_CNT_WIDTH = $clog2(DRAIN_TIMEOUT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DISPATCH_WIDTH-1:0]      commit_en,
    input  logic [DISPATCH_WIDTH-1:0]      commit_mispredict,
    input  logic [DISPATCH_WIDTH-1:0][31:0] commit_target,
    output logic [DISPATCH_WIDTH-1:0]      commit_retire,
    input  logic                           pipe_busy,
    output logic                           flush,
    output logic                           stall_dispatch,
    output logic                           redirect_valid,
    output logic [31:0]                    redirect_pc,
    input  logic                           redirect_ready,
    output logic                           drain_timeout_err,
    output logic                           busy,
    output recovery_state_t                state_dbg
);

    localparam int KW = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;
    localparam logic [DRAIN_CNT_WIDTH-1:0] CNT_LAST = DRAIN_CNT_WIDTH'(DRAIN_TIMEOUT - 1);

    recovery_state_t              state;
    logic [DRAIN_CNT_WIDTH-1:0]   drain_cnt;
    logic                         mp_found;
    logic [KW-1:0]                mp_k;
    logic [DISPATCH_WIDTH-1:0]    mp_mask;

    oldest_mispredict_sel #(.W(DISPATCH_WIDTH), .KW(KW)) u_sel (
        .commit_en         (commit_en),
        .commit_mispredict (commit_mispredict),
        .found             (mp_found),
        .k                 (mp_k),
        .retire_mask       (mp_mask)
    );

    // Redirect handshake: redirect_valid stays high with redirect_pc frozen
    // until the cycle redirect_ready is seen; that cycle completes the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            drain_cnt         <= '0;
            redirect_pc       <= '0;
            drain_timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mp_found) begin
                        state       <= FLUSH;
                        redirect_pc <= commit_target[mp_k];
                    end
                end
                FLUSH: begin
                    drain_cnt <= '0;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state <= REDIRECT;
                    end else if (drain_cnt == CNT_LAST) begin
                        state             <= REDIRECT;
                        drain_timeout_err <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything but the retire mask is decoded from state only.
    assign flush          = (state == FLUSH);
    assign stall_dispatch = (state != IDLE);
    assign redirect_valid = (state == REDIRECT);
    assign busy           = (state != IDLE);
    assign commit_retire  = (state == IDLE) ? mp_mask : '0;
    assign state_dbg      = state;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl: retire-mask vector table plus
// hand-written recovery sequences (drain wait, timeout, handshake, reset).
module tb_rob_recovery_ctrl;
    import rob_recovery_ctrl_pkg::*;

    localparam int W  = DISPATCH_WIDTH;
    localparam int TO = 16;

    logic                 clk;
    logic                 rst;
    logic [W-1:0]         commit_en;
    logic [W-1:0]         commit_mispredict;
    logic [W-1:0][31:0]   commit_target;
    logic [W-1:0]         commit_retire;
    logic                 pipe_busy;
    logic                 flush;
    logic                 stall_dispatch;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 redirect_ready;
    logic                 drain_timeout_err;
    logic                 busy;
    recovery_state_t      state_dbg;

    rob_recovery_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .commit_en         (commit_en),
        .commit_mispredict (commit_mispredict),
        .commit_target     (commit_target),
        .commit_retire     (commit_retire),
        .pipe_busy         (pipe_busy),
        .flush             (flush),
        .stall_dispatch    (stall_dispatch),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_ready    (redirect_ready),
        .drain_timeout_err (drain_timeout_err),
        .busy              (busy),
        .state_dbg         (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [W-1:0] en;
        logic [W-1:0] mp;
        logic [W-1:0] exp_retire;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {flush, stall_dispatch, redirect_valid, busy}
    task automatic check_outs(input string name, input logic [3:0] exp);
        check(name, {28'd0, flush, stall_dispatch, redirect_valid, busy}, {28'd0, exp});
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic clear_commit();
        commit_en         = '0;
        commit_mispredict = '0;
        commit_target     = '0;
    endtask

    // Drives a mispredicting commit for one cycle and ends in the FLUSH cycle.
    task automatic start_mispredict(input logic [W-1:0] en, input logic [W-1:0] mp,
                                    input logic [31:0] t0, input logic [31:0] t1,
                                    input logic [W-1:0] exp_retire, input logic [31:0] exp_pc);
        commit_en         = en;
        commit_mispredict = mp;
        commit_target[0]  = t0;
        commit_target[1]  = t1;
        #1;
        check("retire_mask", {{(32-W){1'b0}}, commit_retire}, {{(32-W){1'b0}}, exp_retire});
        exp_q.push_back(exp_pc);
        cycle();
        clear_commit();
        check_outs("flush_cycle", 4'b1101);
        check("state_flush", 32'(state_dbg), 32'(FLUSH));
    endtask

    // Called in a REDIRECT cycle; completes the handshake and checks IDLE after.
    task automatic accept_redirect(input string name);
        logic [31:0] exp_pc;
        check_outs({name, "_redirect"}, 4'b0111);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_pc: redirect with empty expected queue", name);
        end else begin
            exp_pc = exp_q.pop_front();
            check({name, "_pc"}, redirect_pc, exp_pc);
        end
        redirect_ready = 1'b1;
        cycle();
        check_outs({name, "_idle"}, 4'b0000);
        check({name, "_state_idle"}, 32'(state_dbg), 32'(IDLE));
        redirect_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b1;
        pipe_busy      = 1'b0;
        redirect_ready = 1'b0;
        clear_commit();

        vecs[0] = '{en: 2'b00, mp: 2'b00, exp_retire: 2'b00};
        vecs[1] = '{en: 2'b11, mp: 2'b00, exp_retire: 2'b11};
        vecs[2] = '{en: 2'b11, mp: 2'b01, exp_retire: 2'b01};
        vecs[3] = '{en: 2'b11, mp: 2'b10, exp_retire: 2'b11};
        vecs[4] = '{en: 2'b11, mp: 2'b11, exp_retire: 2'b01};
        vecs[5] = '{en: 2'b10, mp: 2'b01, exp_retire: 2'b10};
        vecs[6] = '{en: 2'b10, mp: 2'b10, exp_retire: 2'b10};
        vecs[7] = '{en: 2'b01, mp: 2'b00, exp_retire: 2'b01};
        vecs[8] = '{en: 2'b01, mp: 2'b11, exp_retire: 2'b01};

        // reset state
        cycle();
        cycle();
        check_outs("reset_outs", 4'b0000);
        check("reset_err", {31'd0, drain_timeout_err}, 32'd0);
        check("reset_pc", redirect_pc, 32'd0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        cycle();

        // IDLE retire mask: inputs withdrawn before the edge so state stays IDLE
        for (int i = 0; i < 9; i++) begin
            commit_en         = vecs[i].en;
            commit_mispredict = vecs[i].mp;
            #1;
            check($sformatf("vec%0d_retire", i), {30'd0, commit_retire}, {30'd0, vecs[i].exp_retire});
            clear_commit();
            cycle();
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        // lane 0 mispredict, fastest path
        redirect_ready = 1'b1;
        start_mispredict(2'b11, 2'b01, 32'h0000_1000, 32'h0000_dead, 2'b01, 32'h0000_1000);
        cycle();
        check_outs("l0_drain", 4'b0101);
        cycle();
        accept_redirect("l0");

        // lane 1 mispredict
        start_mispredict(2'b11, 2'b10, 32'h0000_beef, 32'h0000_2004, 2'b11, 32'h0000_2004);
        cycle();
        check_outs("l1_drain", 4'b0101);
        cycle();
        accept_redirect("l1");

        // drain wait: pipe_busy for 5 DRAIN cycles, ready high but ignored
        pipe_busy      = 1'b1;
        redirect_ready = 1'b1;
        start_mispredict(2'b01, 2'b01, 32'h0000_3000, 32'h0, 2'b01, 32'h0000_3000);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check($sformatf("dw_drain%0d", i), 32'(state_dbg), 32'(DRAIN));
            check_outs($sformatf("dw_outs%0d", i), 4'b0101);
            if (i == 5) pipe_busy = 1'b0;
        end
        cycle();
        check("dw_err", {31'd0, drain_timeout_err}, 32'd0);
        accept_redirect("dw");

        // drain timeout: pipe_busy stuck
        pipe_busy = 1'b1;
        start_mispredict(2'b11, 2'b01, 32'h0000_4000, 32'h0, 2'b01, 32'h0000_4000);
        for (int i = 0; i < TO; i++) begin
            cycle();
            check($sformatf("to_drain%0d", i), 32'(state_dbg), 32'(DRAIN));
            check($sformatf("to_err_low%0d", i), {31'd0, drain_timeout_err}, 32'd0);
        end
        cycle();
        check("to_state_redirect", 32'(state_dbg), 32'(REDIRECT));
        check("to_err_set", {31'd0, drain_timeout_err}, 32'd1);
        pipe_busy = 1'b0;
        accept_redirect("to");
        check("to_err_sticky", {31'd0, drain_timeout_err}, 32'd1);

        // handshake hold with mispredicts pulsed during REDIRECT
        start_mispredict(2'b11, 2'b01, 32'h0000_1000, 32'h0, 2'b01, 32'h0000_1000);
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            check_outs($sformatf("hs_hold%0d", i), 4'b0111);
            check($sformatf("hs_pc%0d", i), redirect_pc, 32'h0000_1000);
            commit_en         = 2'b11;
            commit_mispredict = 2'b01;
            commit_target[0]  = 32'h0000_5555;
            #1;
            check($sformatf("hs_retire%0d", i), {30'd0, commit_retire}, 32'd0);
            cycle();
        end
        clear_commit();
        accept_redirect("hs");
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_outs($sformatf("hs_no_reflush%0d", i), 4'b0000);
        end
        check("hs_err_sticky", {31'd0, drain_timeout_err}, 32'd1);

        rst = 1'b1;
        cycle();
        check("rst_clears_err", {31'd0, drain_timeout_err}, 32'd0);
        rst = 1'b0;
        cycle();

        // reset in the middle of DRAIN
        pipe_busy = 1'b1;
        start_mispredict(2'b01, 2'b01, 32'h0000_7000, 32'h0, 2'b01, 32'h0000_7000);
        cycle();
        cycle();
        check("mid_state_drain", 32'(state_dbg), 32'(DRAIN));
        rst = 1'b1;
        cycle();
        check_outs("mid_rst_outs", 4'b0000);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        check("mid_rst_pc", redirect_pc, 32'd0);
        void'(exp_q.pop_back());
        rst       = 1'b0;
        pipe_busy = 1'b0;
        cycle();
        start_mispredict(2'b11, 2'b10, 32'h0, 32'h0000_2004, 2'b11, 32'h0000_2004);
        cycle();
        check_outs("post_rst_drain", 4'b0101);
        cycle();
        accept_redirect("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
